// File: rtl/drm_metering_event_gen.sv
// Purpose: qualifies the Activator code into ip_enable and drains counted usage as metering events.
// Latency: ip_enable 1 cycle after code_ok; first event valid 2 cycles after the first usage pulse.
// Backpressure: metering_event holds until event_accepted; usage accumulates (saturating) meanwhile.
module drm_metering_event_gen #(
    parameter int                        CNT_WIDTH         = 16,
    parameter int                        ACT_CODE_WIDTH    = 128,
    parameter logic [ACT_CODE_WIDTH-1:0] ACT_CODE_MASK     = '1,
    parameter logic [ACT_CODE_WIDTH-1:0] ACT_CODE_EXPECTED = '0
) (
    input  logic                      ip_core_aclk,
    input  logic                      ip_core_rst,
    input  logic                      activation_code_ready,
    input  logic [ACT_CODE_WIDTH-1:0] activation_code,
    input  logic                      usage_evt,
    output logic                      metering_event,
    input  logic                      event_accepted,
    output logic                      ip_enable,
    output logic [CNT_WIDTH-1:0]      pending_cnt,
    output logic                      overflow
);

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        IDLE   = 2'd1,
        REQ    = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q;
    state_t               state_d;
    logic                 code_ok;
    logic                 inc;
    logic                 dec;
    logic                 ovf_set;
    logic [CNT_WIDTH-1:0] pending_d;

    // The ready gate keeps an undriven code bus from leaking into the compare.
    assign code_ok        = activation_code_ready &
                            ((activation_code & ACT_CODE_MASK) == ACT_CODE_EXPECTED);
    assign metering_event = (state_q == REQ);
    assign inc            = usage_evt & ip_enable;
    assign dec            = metering_event & event_accepted;

    always_comb begin
        pending_d = pending_cnt;
        ovf_set   = 1'b0;
        case ({inc, dec})
            2'b10: begin
                if (&pending_cnt) begin
                    ovf_set = 1'b1;
                end else begin
                    pending_d = pending_cnt + CNT_ONE;
                end
            end
            2'b01:   pending_d = pending_cnt - CNT_ONE;
            default: pending_d = pending_cnt;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOCKED: begin
                if (code_ok) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!code_ok) begin
                    state_d = LOCKED;
                end else if (pending_cnt != '0) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // A raised request is never retracted; losing the code only matters after the transfer.
                if (dec) begin
                    if (!code_ok) begin
                        state_d = LOCKED;
                    end else if (pending_d != '0) begin
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = LOCKED;
        endcase
    end

    always_ff @(posedge ip_core_aclk) begin
        if (ip_core_rst) begin
            state_q     <= LOCKED;
            ip_enable   <= 1'b0;
            pending_cnt <= '0;
            overflow    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ip_enable   <= code_ok;
            pending_cnt <= pending_d;
            if (ovf_set) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_drm_metering_event_gen.sv
// Directed bench for drm_metering_event_gen with a queue scoreboard of expected metering events.
module tb_drm_metering_event_gen;

    localparam int CW = 4;
    localparam int AW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready;
    logic [AW-1:0] code;
    logic          usage;
    logic          accepted;
    logic          meter;
    logic          ena;
    logic [CW-1:0] pend;
    logic          ovf;

    int n_cmp = 0;
    int n_err = 0;
    int xfer_cnt = 0;
    int xfer_base;
    int seq = 0;
    int sb_q[$];

    always #5 clk = ~clk;

    drm_metering_event_gen #(
        .CNT_WIDTH(CW),
        .ACT_CODE_WIDTH(AW)
    ) dut (
        .ip_core_aclk         (clk),
        .ip_core_rst          (rst),
        .activation_code_ready(ready),
        .activation_code      (code),
        .usage_evt            (usage),
        .metering_event       (meter),
        .event_accepted       (accepted),
        .ip_enable            (ena),
        .pending_cnt          (pend),
        .overflow             (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_evt();
        sb_q.push_back(seq);
        seq++;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((pend != '0 || meter) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, (n < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Each handshake completes on the coming edge; it must match an outstanding expected event.
    always @(negedge clk) begin
        if (!rst && meter && accepted) begin
            xfer_cnt++;
            chk("xfer_has_expected_event", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb_q.size() > 0) begin
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ready = 1'b0; code = '0; usage = 1'b0; accepted = 1'b0;

        // Reset and activation
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_outputs_zero", {28'd0, ena, meter, ovf, |pend}, 32'd0);
        end
        rst = 1'b0;
        ready = 1'b1; code = 128'h1;
        tick();
        chk("mismatch_code_ena", ena, 0);
        tick();
        chk("mismatch_code_ena_hold", ena, 0);
        code = '0;
        tick();
        chk("match_code_ena_1cyc", ena, 1);

        // Single event with delayed accept
        usage = 1'b1; push_evt();
        tick();
        usage = 1'b0;
        chk("single_pend_1", pend, 1);
        chk("single_meter_not_yet", meter, 0);
        tick();
        chk("single_meter_rise_t2", meter, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("single_meter_held", meter, 1);
        end
        accepted = 1'b1;
        tick();
        accepted = 1'b0;
        chk("single_meter_fall", meter, 0);
        chk("single_pend_0", pend, 0);
        chk("single_sb_empty", sb_q.size(), 0);

        // Burst of 10 with accept tied high
        xfer_base = xfer_cnt;
        accepted = 1'b1;
        for (int i = 0; i < 10; i++) begin
            usage = 1'b1; push_evt();
            tick();
        end
        usage = 1'b0;
        wait_drain("burst_drain_timeout", 40);
        chk("burst_xfers", xfer_cnt - xfer_base, 10);
        chk("burst_pend_0", pend, 0);
        chk("burst_no_ovf", ovf, 0);
        chk("burst_sb_empty", sb_q.size(), 0);
        accepted = 1'b0;
        tick();

        // Lock while a request is outstanding
        for (int i = 0; i < 3; i++) begin
            usage = 1'b1; push_evt();
            tick();
        end
        usage = 1'b0;
        chk("lock_pend_3", pend, 3);
        chk("lock_meter_hi", meter, 1);
        ready = 1'b0; code = {AW{1'b1}};
        tick();
        chk("lock_ena_drop", ena, 0);
        chk("lock_meter_held", meter, 1);
        tick();
        chk("lock_meter_held2", meter, 1);
        accepted = 1'b1;
        tick();
        accepted = 1'b0;
        chk("lock_meter_fall", meter, 0);
        chk("lock_pend_2", pend, 2);
        usage = 1'b1;
        tick();
        usage = 1'b0;
        chk("lock_usage_ignored", pend, 2);
        chk("lock_stay_locked", meter, 0);
        xfer_base = xfer_cnt;
        ready = 1'b1; code = '0; accepted = 1'b1;
        tick();
        chk("reactivate_ena", ena, 1);
        wait_drain("reactivate_drain_timeout", 20);
        chk("reactivate_xfers", xfer_cnt - xfer_base, 2);
        chk("reactivate_sb_empty", sb_q.size(), 0);
        accepted = 1'b0;
        tick();

        // Saturation at 15
        for (int i = 0; i < 20; i++) begin
            usage = 1'b1;
            if (sb_q.size() < 15) push_evt();
            tick();
        end
        chk("sat_pend_15", pend, 15);
        chk("sat_ovf", ovf, 1);
        accepted = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_evt();
            tick();
            chk("sat_inc_dec_hold", pend, 15);
        end
        usage = 1'b0;
        wait_drain("sat_drain_timeout", 40);
        chk("sat_sb_empty", sb_q.size(), 0);
        chk("sat_ovf_sticky", ovf, 1);
        accepted = 1'b0;
        tick();

        // Reset mid-handshake
        for (int i = 0; i < 7; i++) begin
            usage = 1'b1; push_evt();
            tick();
        end
        usage = 1'b0;
        tick();
        chk("midrst_pre_pend_7", pend, 7);
        chk("midrst_pre_meter", meter, 1);
        rst = 1'b1; accepted = 1'b1;
        tick();
        sb_q.delete();
        chk("midrst_meter_0", meter, 0);
        chk("midrst_pend_0", pend, 0);
        chk("midrst_ovf_0", ovf, 0);
        chk("midrst_ena_0", ena, 0);
        rst = 1'b0; accepted = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
